instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch front end: drives the word address into the 16-entry combinational
//  instruction memory and captures the returned 16-bit instruction into the IF/ID register.
//  Sequences the PC (increment, hold on stall, redirect on taken branch) and injects
//  NOP bubbles (16'hF000) after a redirect. Sits between the instruction memory and decode.
// PARAMETERS
//  PC_W        6        PC / address width, word-addressed; memory decodes PC[3:0]
//  INSTR_W     16       instruction width
//  RESET_PC    6'd0     PC value loaded on reset
//  NOP_INSTR   16'hF000 bubble encoding written to IF/ID on flush/reset
//  FLUSH_SLOTS 1        bubble cycles per taken branch (1..7)
// PORTS
//  CLK         in   1        clock, rising edge
//  RST_N       in   1        asynchronous, active-low reset
//  PCO         out  PC_W     fetch address to instruction memory (= PC register)
//  INSTR_IN    in   INSTR_W  instruction returned combinationally for PCO
//  STALL       in   1        hazard stall from decode: hold PC and IF/ID
//  BR_TAKEN    in   1        taken-branch redirect from execute (one-cycle pulse)
//  BR_TARGET   in   PC_W     redirect address, sampled when BR_TAKEN=1
//  IFID_INSTR  out  INSTR_W  registered instruction to decode
//  IFID_PC     out  PC_W     registered address of IFID_INSTR
//  IFID_VALID  out  1        1 = IFID_INSTR is a real fetch, 0 = bubble
//  FETCH_CNT   out  16       count of valid instructions delivered, wraps at 2^16
// BEHAVIOUR
//  Reset (async, RST_N=0): PC=RESET_PC, IFID_INSTR=NOP_INSTR, IFID_PC=0, IFID_VALID=0,
//   FETCH_CNT=0, state=BOOT, flush counter=0. Applies immediately, including mid-flush/stall.
//  States: BOOT, RUN, FLUSH.
//  BOOT: first edge after reset release -> RUN; no capture, PC held, IF/ID unchanged.
//  RUN, priority BR_TAKEN > STALL > normal:
//   normal: IFID_INSTR<=INSTR_IN, IFID_PC<=PC, IFID_VALID<=1, PC<=PC+1, FETCH_CNT+=1.
//   STALL=1: PC, IFID_*, FETCH_CNT hold.
//   BR_TAKEN=1: PC<=BR_TARGET; IFID_INSTR<=NOP_INSTR, IFID_VALID<=0, IFID_PC holds;
//    FLUSH_SLOTS>1 -> FLUSH with counter=FLUSH_SLOTS-1, else stay in RUN.
//  FLUSH: PC holds, IF/ID keeps the bubble, counter decrements; counter hits 1 -> RUN.
//   STALL ignored in FLUSH (bubbles never held). BR_TAKEN in FLUSH: PC<=new BR_TARGET,
//   counter reloads FLUSH_SLOTS-1.
//  Latency: instruction at address A reaches IFID_INSTR on the edge after PCO=A.
//   Redirect to T: IFID_PC=T no earlier than FLUSH_SLOTS+1 edges after the BR_TAKEN edge.
//  Arithmetic: PC+1 is modulo 2^PC_W (63->0). The memory aliases PC[5:4]; no fault.
//  STALL and BR_TAKEN together: branch wins, stall dropped for that cycle.
//  BR_TAKEN in BOOT: ignored.
//  All outputs driven directly from registers; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared header mips_defs.vh: NOP_INSTR, INSTR_W, PC_W, fetch state encodings
//   (BOOT=2'd0, RUN=2'd1, FLUSH=2'd2).
//  One sub-module, pc_next_sel (combinational): selects PC+1 / hold / BR_TARGET from
//   state, STALL and BR_TAKEN. The rest is inline: FSM, flush counter, IF/ID register,
//   FETCH_CNT.
// TESTING (bench holds a 16-entry model memory feeding INSTR_IN from PCO[3:0])
//  1 Reset then release, mem[0]=16'h2213: edge1 BOOT; edge2 IFID_INSTR=2213, IFID_PC=0,
//    VALID=1, PCO=1, FETCH_CNT=1.
//  2 STALL high 3 cycles at PC=4: PCO stays 4, IFID_PC stays 3, FETCH_CNT unchanged;
//    STALL low -> IFID_PC=4 next edge.
//  3 BR_TAKEN with BR_TARGET=1 at PC=7, FLUSH_SLOTS=1: next edge VALID=0,
//    IFID_INSTR=F000, PCO=1. Following edge: IFID_PC=1, VALID=1.
//    Repeat with FLUSH_SLOTS=3: two more bubble cycles.
//  4 STALL=1 and BR_TAKEN=1 on the same cycle, target 9: redirect taken, PCO=9, bubble.
//  5 Free-run from PC=62: PCO goes 62,63,0,1; IFID_PC follows one cycle behind;
//    IFID_INSTR at PC 63 = mem[15].
//  6 RST_N pulsed low mid-FLUSH (async, between edges): outputs reset immediately,
//    VALID=0, PCO=RESET_PC; BOOT sequence repeats.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the fetch front end.
// Imported by the fetch unit, its PC selector and the bench.
package instr_fetch_unit_pkg;

    localparam int IF_PC_W    = 6;
    localparam int IF_INSTR_W = 16;
    localparam int IF_CNT_W   = 16;

    localparam logic [IF_INSTR_W-1:0] IF_NOP_INSTR = 16'hF000;
    localparam logic [IF_PC_W-1:0]    IF_RESET_PC  = 6'd0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // Counter value loaded on a redirect; stays in range 0..6.
    function automatic logic [2:0] flush_reload(input int slots);
        return 3'(slots - 1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory port, hazard/redirect inputs
// and the IF/ID register outputs toward decode.
interface instr_fetch_if #(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 16
) ();

    logic [PC_W-1:0]    pco;
    logic [INSTR_W-1:0] instr_in;
    logic               stall;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic [INSTR_W-1:0] ifid_instr;
    logic [PC_W-1:0]    ifid_pc;
    logic               ifid_valid;
    logic [15:0]        fetch_cnt;

    modport master (
        output pco,
        output ifid_instr,
        output ifid_pc,
        output ifid_valid,
        output fetch_cnt,
        input  instr_in,
        input  stall,
        input  br_taken,
        input  br_target
    );

    modport slave (
        input  pco,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_valid,
        input  fetch_cnt,
        output instr_in,
        output stall,
        output br_taken,
        output br_target
    );

endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC mux: sequential increment, hold, or branch redirect,
// chosen from the fetch state and the stall/branch inputs.
module pc_next_sel
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W = 6
) (
    input  fetch_state_t    i_state,
    input  logic            i_stall,
    input  logic            i_br_taken,
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_br_target,
    output logic [PC_W-1:0] o_pc_next
);

    always_comb begin
        o_pc_next = i_pc;
        unique case (i_state)
            ST_RUN: begin
                if (i_br_taken)
                    o_pc_next = i_br_target;
                else if (!i_stall)
                    o_pc_next = i_pc + PC_W'(1);
            end
            ST_FLUSH: begin
                if (i_br_taken)
                    o_pc_next = i_br_target;
            end
            default: o_pc_next = i_pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC sequencing, IF/ID capture,
// post-redirect bubble injection and delivered-instruction count.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                 PC_W        = IF_PC_W,
    parameter int                 INSTR_W     = IF_INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC    = IF_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = IF_NOP_INSTR,
    parameter int                 FLUSH_SLOTS = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    instr_fetch_if.master io_bus
);

    localparam logic [2:0] LP_RELOAD = flush_reload(FLUSH_SLOTS);
    localparam bit         LP_FLUSH  = (FLUSH_SLOTS > 1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [2:0]         r_flush_cnt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [PC_W-1:0]    r_ifid_pc;
    logic               r_ifid_valid;
    logic [15:0]        r_fetch_cnt;

    logic w_capture;
    logic w_inject;
    logic w_cnt_dec;

    pc_next_sel #(
        .PC_W (PC_W)
    ) u_pc_next_sel (
        .i_state     (r_state),
        .i_stall     (io_bus.stall),
        .i_br_taken  (io_bus.br_taken),
        .i_pc        (r_pc),
        .i_br_target (io_bus.br_target),
        .o_pc_next   (w_pc_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (io_bus.br_taken && LP_FLUSH)
                    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!io_bus.br_taken && r_flush_cnt <= 3'd1)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_inject  = 1'b0;
        w_cnt_dec = 1'b0;
        unique case (1'b1)
            (r_state == ST_RUN): begin
                w_inject  = io_bus.br_taken;
                w_capture = !io_bus.br_taken && !io_bus.stall;
            end
            (r_state == ST_FLUSH): begin
                w_inject  = io_bus.br_taken;
                w_cnt_dec = !io_bus.br_taken;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_flush_cnt <= 3'd0;
        else if (w_inject)
            r_flush_cnt <= LP_RELOAD;
        else if (w_cnt_dec && r_flush_cnt != 3'd0)
            r_flush_cnt <= r_flush_cnt - 3'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    // IFID_PC is left alone on a bubble so decode still sees the last real address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
            r_fetch_cnt  <= 16'd0;
        end else if (w_inject) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (w_capture) begin
            r_ifid_instr <= io_bus.instr_in;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b1;
            r_fetch_cnt  <= r_fetch_cnt + 16'd1;
        end
    end

    assign io_bus.pco        = r_pc;
    assign io_bus.ifid_instr = r_ifid_instr;
    assign io_bus.ifid_pc    = r_ifid_pc;
    assign io_bus.ifid_valid = r_ifid_valid;
    assign io_bus.fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (1 and 3 flush slots) share
// stimulus; an abstract fetch model fills scoreboards checked by a monitor.
module tb_instr_fetch_unit;

    typedef struct {
        int pc;
        bit boot;
        int bub;
        int instr;
        int ipc;
        int valid;
        int cnt;
    } model_t;

    typedef struct {
        int pco;
        int instr;
        int ipc;
        int valid;
        int cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [15:0] mem [16];

    int n_chk;
    int n_fail;
    int n_push;
    int n_pop;

    model_t m1;
    model_t m3;
    exp_t   q1[$];
    exp_t   q3[$];

    instr_fetch_if #(.PC_W(6), .INSTR_W(16)) if1 ();
    instr_fetch_if #(.PC_W(6), .INSTR_W(16)) if3 ();

    assign if1.instr_in = mem[if1.pco[3:0]];
    assign if3.instr_in = mem[if3.pco[3:0]];

    instr_fetch_unit #(.FLUSH_SLOTS(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (if1)
    );

    instr_fetch_unit #(.FLUSH_SLOTS(3)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic model_t m_reset();
        model_t m;
        m.pc = 0; m.boot = 1'b1; m.bub = 0;
        m.instr = 16'hF000; m.ipc = 0; m.valid = 0; m.cnt = 0;
        return m;
    endfunction

    // One clock edge of the fetch rules: boot edge, bubble slots, then
    // branch > stall > sequential fetch.
    function automatic model_t m_step(input model_t m, input bit rst,
                                      input bit st, input bit br,
                                      input int tgt, input int slots);
        if (!rst) return m_reset();
        if (m.boot) begin
            m.boot = 1'b0;
        end else if (br) begin
            m.pc = tgt;
            m.instr = 16'hF000;
            m.valid = 0;
            m.bub = slots - 1;
        end else if (m.bub > 0) begin
            m.bub--;
        end else if (!st) begin
            m.instr = mem[m.pc % 16];
            m.ipc = m.pc;
            m.valid = 1;
            m.pc = (m.pc + 1) % 64;
            m.cnt = (m.cnt + 1) % 65536;
        end
        return m;
    endfunction

    function automatic exp_t snap(input model_t m);
        exp_t e;
        e.pco = m.pc; e.instr = m.instr; e.ipc = m.ipc;
        e.valid = m.valid; e.cnt = m.cnt;
        return e;
    endfunction

    task automatic cycle(input bit rst, input bit st,
                         input bit br, input int tgt);
        @(negedge clk);
        rst_n = rst;
        if1.stall = st; if1.br_taken = br; if1.br_target = 6'(tgt);
        if3.stall = st; if3.br_taken = br; if3.br_target = 6'(tgt);
        m1 = m_step(m1, rst, st, br, tgt, 1);
        m3 = m_step(m3, rst, st, br, tgt, 3);
        q1.push_back(snap(m1));
        q3.push_back(snap(m3));
        n_push++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic cmp(input string tag, input exp_t e,
                       input int pco, input int instr, input int ipc,
                       input int valid, input int cnt);
        chk({tag, "_pco"}, pco, e.pco);
        chk({tag, "_instr"}, instr, e.instr);
        chk({tag, "_ifid_pc"}, ipc, e.ipc);
        chk({tag, "_valid"}, valid, e.valid);
        chk({tag, "_cnt"}, cnt, e.cnt);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q1.size() > 0 && q3.size() > 0) begin
            exp_t e1;
            exp_t e3;
            e1 = q1.pop_front();
            e3 = q3.pop_front();
            n_pop++;
            cmp("fs1", e1, int'(if1.pco), int'(if1.ifid_instr),
                int'(if1.ifid_pc), int'(if1.ifid_valid),
                int'(if1.fetch_cnt));
            cmp("fs3", e3, int'(if3.pco), int'(if3.ifid_instr),
                int'(if3.ifid_pc), int'(if3.ifid_valid),
                int'(if3.fetch_cnt));
        end
    end

    initial begin
        exp_t er;
        n_chk = 0; n_fail = 0; n_push = 0; n_pop = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h2213;
        rst_n = 1'b0;
        if1.stall = 1'b0; if1.br_taken = 1'b0; if1.br_target = '0;
        if3.stall = 1'b0; if3.br_taken = 1'b0; if3.br_target = '0;
        m1 = m_reset();
        m3 = m_reset();

        cycle(1'b0, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0);
        // release, boot edge, then fetch 0..3 so PC reaches 4
        run(5);
        cycle(1'b1, 1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 1'b0, 0);
        run(3);
        cycle(1'b1, 1'b0, 1'b1, 1);
        run(5);
        cycle(1'b1, 1'b1, 1'b1, 9);
        run(5);
        cycle(1'b1, 1'b0, 1'b1, 62);
        run(8);
        // branch, step once into the bubble window, then async reset
        cycle(1'b1, 1'b0, 1'b1, 5);
        run(1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m1 = m_reset();
        m3 = m_reset();
        #1;
        er = snap(m1);
        cmp("async_rst1", er, int'(if1.pco), int'(if1.ifid_instr),
            int'(if1.ifid_pc), int'(if1.ifid_valid),
            int'(if1.fetch_cnt));
        er = snap(m3);
        cmp("async_rst3", er, int'(if3.pco), int'(if3.ifid_instr),
            int'(if3.ifid_pc), int'(if3.ifid_valid),
            int'(if3.fetch_cnt));
        cycle(1'b0, 1'b0, 1'b1, 7);
        run(6);

        for (int i = 0; i < 600; i++) begin
            bit st;
            bit br;
            st = ($urandom_range(3) == 0);
            br = ($urandom_range(7) == 0);
            cycle(1'b1, st, br, int'($urandom_range(63)));
        end

        @(posedge clk);
        #2;
        chk("sb_drain", q1.size() + q3.size(), 0);
        chk("sb_count", n_pop, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
